// File: rtl/fft_pkg.sv
// Shared types and arithmetic helpers for the in-place radix-2 FFT frame engine.
package fft_pkg;

  localparam int unsigned CplxW = 16;
  localparam int unsigned AccW  = 64;

  typedef logic signed [AccW-1:0] acc_t;

  typedef struct packed {
    logic signed [CplxW-1:0] re;
    logic signed [CplxW-1:0] im;
  } complex_t;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCompute,
    StUnload
  } fft_state_e;

  // Reverse the low 'bits' bits of v.
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int unsigned bits);
    logic [15:0] r;
    r = {<<{v}};
    return r >> (16 - bits);
  endfunction

  function automatic acc_t sat_clip(input acc_t v, input int unsigned w);
    acc_t hi;
    acc_t lo;
    acc_t res;
    hi  = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
    lo  = -(acc_t'(1) <<< (w - 1));
    res = v;
    if (v > hi) res = hi;
    if (v < lo) res = lo;
    return res;
  endfunction

  function automatic acc_t sat_add(input acc_t a, input acc_t b, input int unsigned w,
                                   input logic halve);
    acc_t s;
    s = a + b;
    if (halve) s = s >>> 1;
    return sat_clip(s, w);
  endfunction

  function automatic acc_t sat_sub(input acc_t a, input acc_t b, input int unsigned w,
                                   input logic halve);
    acc_t s;
    s = a - b;
    if (halve) s = s >>> 1;
    return sat_clip(s, w);
  endfunction

  // Half an LSB of a Q1.(tw_w-1) product, added before the renormalising shift.
  function automatic acc_t round_half(input int unsigned tw_w);
    return acc_t'(1) <<< (tw_w - 2);
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Constant twiddle table: k -> cos(2*pi*k/N) and -sin(2*pi*k/N) in Q1.(TW_W-1).
module fft_twiddle_rom #(
  parameter int unsigned N_POINTS = 16,
  parameter int unsigned TW_W     = 16
) (
  input  logic        [$clog2(N_POINTS)-2:0] k,
  output logic signed [TW_W-1:0]             w_re,
  output logic signed [TW_W-1:0]             w_im
);

  localparam int unsigned HalfN = N_POINTS / 2;
  localparam real         Pi    = 3.14159265358979323846;
  localparam real         Scale = 2.0 ** (TW_W - 1);
  localparam int          MaxQ  = (1 << (TW_W - 1)) - 1;

  logic signed [TW_W-1:0] cos_tab  [HalfN];
  logic signed [TW_W-1:0] msin_tab [HalfN];

  for (genvar i = 0; i < HalfN; i++) begin : g_tab
    localparam real Ang  = 2.0 * Pi * real'(i) / real'(N_POINTS);
    localparam int  CRaw = int'($cos(Ang) * Scale);
    localparam int  SRaw = -int'($sin(Ang) * Scale);
    // +1.0 only occurs at k = 0, which the engine bypasses; clamp keeps the entry legal.
    localparam int  CQ   = (CRaw > MaxQ) ? MaxQ : CRaw;
    assign cos_tab[i]  = TW_W'(CQ);
    assign msin_tab[i] = TW_W'(SRaw);
  end

  assign w_re = cos_tab[k];
  assign w_im = msin_tab[k];

endmodule

// File: rtl/fft_frame_engine.sv
// Frame-level FFT engine: loads N samples bit-reversed, runs all radix-2 DIT stages
// one butterfly per cycle over a ping-pong buffer, then streams the spectrum out.
module fft_frame_engine
  import fft_pkg::*;
#(
  parameter int unsigned N_POINTS = 16,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned TW_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        inverse,
  input  logic                        scale_en,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic [$clog2(N_POINTS)-1:0] out_index,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned L  = $clog2(N_POINTS);
  localparam int unsigned Kw = L - 1;
  localparam int unsigned Hw = WIDTH / 2;
  localparam int unsigned Sw = $clog2(L);

  fft_state_e     state_q, state_d;
  logic           inv_q, inv_d;
  logic           scl_q, scl_d;
  logic [L-1:0]   load_cnt_q, load_cnt_d;
  logic [Sw-1:0]  stage_q, stage_d;
  logic [Kw-1:0]  bfly_q, bfly_d;
  logic [L-1:0]   unload_cnt_q, unload_cnt_d;
  logic           bank_q, bank_d;
  logic           done_q, done_d;
  logic           we_load, we_bfly;

  logic [WIDTH-1:0] mem_q [2][N_POINTS];

  logic [L-1:0]            bfly_ext, half, grp, j, idx_p, idx_q, load_addr;
  logic [Kw-1:0]           tw_k;
  logic [WIDTH-1:0]        a_word, b_word, y0, y1;
  logic signed [TW_W-1:0]  w_re, w_im_rom;
  acc_t                    ar, ai, br, bi, wr, wi, t_re, t_im;

  fft_twiddle_rom #(
    .N_POINTS (N_POINTS),
    .TW_W     (TW_W)
  ) u_twiddle_rom (
    .k    (tw_k),
    .w_re (w_re),
    .w_im (w_im_rom)
  );

  // Butterfly addressing and arithmetic for the current (stage, butterfly) pair.
  always_comb begin
    bfly_ext  = {1'b0, bfly_q};
    half      = L'(1) << stage_q;
    grp       = bfly_ext >> stage_q;
    j         = bfly_ext & (half - L'(1));
    idx_p     = ((grp << stage_q) << 1) | j;
    idx_q     = idx_p | half;
    tw_k      = Kw'(j << (Sw'(L - 1) - stage_q));
    load_addr = L'(bitrev(16'(load_cnt_q), L));

    a_word = mem_q[bank_q][idx_p];
    b_word = mem_q[bank_q][idx_q];
    ar     = acc_t'(signed'(a_word[WIDTH-1:Hw]));
    ai     = acc_t'(signed'(a_word[Hw-1:0]));
    br     = acc_t'(signed'(b_word[WIDTH-1:Hw]));
    bi     = acc_t'(signed'(b_word[Hw-1:0]));
    wr     = acc_t'(w_re);
    wi     = inv_q ? -acc_t'(w_im_rom) : acc_t'(w_im_rom);

    if (tw_k == '0) begin
      t_re = br;
      t_im = bi;
    end else begin
      t_re = ((br * wr) - (bi * wi) + round_half(TW_W)) >>> (TW_W - 1);
      t_im = ((br * wi) + (bi * wr) + round_half(TW_W)) >>> (TW_W - 1);
    end

    y0 = {Hw'(sat_add(ar, t_re, Hw, scl_q)), Hw'(sat_add(ai, t_im, Hw, scl_q))};
    y1 = {Hw'(sat_sub(ar, t_re, Hw, scl_q)), Hw'(sat_sub(ai, t_im, Hw, scl_q))};
  end

  always_comb begin
    state_d      = state_q;
    inv_d        = inv_q;
    scl_d        = scl_q;
    load_cnt_d   = load_cnt_q;
    stage_d      = stage_q;
    bfly_d       = bfly_q;
    unload_cnt_d = unload_cnt_q;
    bank_d       = bank_q;
    done_d       = 1'b0;
    we_load      = 1'b0;
    we_bfly      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StLoad;
          inv_d        = inverse;
          scl_d        = scale_en;
          load_cnt_d   = '0;
          stage_d      = '0;
          bfly_d       = '0;
          unload_cnt_d = '0;
          bank_d       = 1'b0;
        end
      end
      StLoad: begin
        if (in_valid) begin
          we_load    = 1'b1;
          load_cnt_d = load_cnt_q + L'(1);
          if (load_cnt_q == '1) begin
            state_d = StCompute;
            stage_d = '0;
            bfly_d  = '0;
          end
        end
      end
      StCompute: begin
        we_bfly = 1'b1;
        bfly_d  = bfly_q + Kw'(1);
        if (bfly_q == '1) begin
          bank_d = ~bank_q;
          if (stage_q == Sw'(L - 1)) begin
            state_d      = StUnload;
            unload_cnt_d = '0;
          end else begin
            stage_d = stage_q + Sw'(1);
          end
        end
      end
      StUnload: begin
        if (out_ready) begin
          unload_cnt_d = unload_cnt_q + L'(1);
          if (unload_cnt_q == '1) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      inv_q        <= 1'b0;
      scl_q        <= 1'b0;
      load_cnt_q   <= '0;
      stage_q      <= '0;
      bfly_q       <= '0;
      unload_cnt_q <= '0;
      bank_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      inv_q        <= inv_d;
      scl_q        <= scl_d;
      load_cnt_q   <= load_cnt_d;
      stage_q      <= stage_d;
      bfly_q       <= bfly_d;
      unload_cnt_q <= unload_cnt_d;
      bank_q       <= bank_d;
      done_q       <= done_d;
    end
  end

  // Sample buffer has no reset; every location is written before it is read.
  always_ff @(posedge clk) begin
    if (!rst && we_load) begin
      mem_q[1'b0][load_addr] <= in_data;
    end
    if (!rst && we_bfly) begin
      mem_q[~bank_q][idx_p] <= y0;
      mem_q[~bank_q][idx_q] <= y1;
    end
  end

  always_comb begin
    in_ready  = (state_q == StLoad);
    out_valid = (state_q == StUnload);
    out_index = out_valid ? unload_cnt_q : '0;
    out_data  = out_valid ? mem_q[bank_q][unload_cnt_q] : '0;
    busy      = (state_q != StIdle);
    done      = done_q;
  end

endmodule

// File: tb/tb_fft_frame_engine.sv
// Directed and randomized frames checked against a floating-point DFT reference.
module tb_fft_frame_engine;
  import fft_pkg::*;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst, start, inverse, scale_en, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid, busy, done;
  logic [31:0] out_data;
  logic [3:0]  out_index;

  int  vectors;
  int  miscompares;
  int  x_re [N];
  int  x_im [N];
  int  got_re [N];
  int  got_im [N];
  real exp_re [N];
  real exp_im [N];

  fft_frame_engine #(
    .N_POINTS (16),
    .WIDTH    (32),
    .TW_W     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .inverse   (inverse),
    .scale_en  (scale_en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_index (out_index),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    vectors++;
    assert (got === expv) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic chk_tol(input string tag, input int bin, input int got, input real expv,
                         input real tol);
    real d;
    vectors++;
    d = real'(got) - expv;
    assert ((d <= tol) && (d >= -tol)) else begin
      miscompares++;
      $error("FAIL %s[%0d]: got %0d expected %0.2f tol %0.1f", tag, bin, got, expv, tol);
    end
  endtask

  // Direct DFT (or IDFT) of x, divided by N when every stage halves.
  task automatic ref_model(input bit inv, input bit scl);
    real ph, sr, si;
    for (int k = 0; k < N; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < N; n++) begin
        ph = 2.0 * 3.14159265358979323846 * real'(n * k) / real'(N);
        if (!inv) ph = -ph;
        sr += real'(x_re[n]) * $cos(ph) - real'(x_im[n]) * $sin(ph);
        si += real'(x_re[n]) * $sin(ph) + real'(x_im[n]) * $cos(ph);
      end
      exp_re[k] = scl ? sr / real'(N) : sr;
      exp_im[k] = scl ? si / real'(N) : si;
    end
  endtask

  task automatic cmp_all(input string tag, input real tol);
    for (int k = 0; k < N; k++) begin
      chk_tol({tag, "_re"}, k, got_re[k], exp_re[k], tol);
      chk_tol({tag, "_im"}, k, got_im[k], exp_im[k], tol);
    end
  endtask

  task automatic fill_random(input int amp);
    for (int n = 0; n < N; n++) begin
      x_re[n] = int'($urandom_range(0, 2 * amp)) - amp;
      x_im[n] = int'($urandom_range(0, 2 * amp)) - amp;
    end
  endtask

  // Runs one frame cycle by cycle; abort_at > 0 pulses rst on that cycle instead.
  task automatic run_frame(input bit inv, input bit scl, input bit bp, input bit glitch,
                           input int abort_at, output int done_cyc);
    int          cyc, ld, ul;
    bit          stalled, take_in, take_out;
    logic [31:0] prev_data;
    logic [3:0]  prev_idx;
    logic [3:0]  pat;
    complex_t    c;
    pat       = 4'b1001;
    done_cyc  = -1;
    ld        = 0;
    ul        = 0;
    stalled   = 1'b0;
    prev_data = '0;
    prev_idx  = '0;
    inverse   = inv;
    scale_en  = scl;
    start     = 1'b1;
    in_valid  = 1'b1;
    in_data   = $urandom;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    inverse  = ~inv;
    scale_en = ~scl;
    cyc      = 1;
    while (cyc < 1000) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
          chk("abort_no_done", done, 0);
          @(posedge clk);
          #1;
        end
        return;
      end
      start     = glitch && (cyc == 25);
      in_valid  = 1'b1;
      in_data   = (ld < N) ? {16'(x_re[ld]), 16'(x_im[ld])} : $urandom;
      out_ready = bp ? pat[cyc % 4] : 1'b1;
      if (stalled) begin
        chk("stall_data", out_data, prev_data);
        chk("stall_index", out_index, prev_idx);
      end
      take_in  = in_ready && in_valid;
      take_out = out_valid && out_ready;
      if (take_out) begin
        chk("out_index", out_index, ul);
        if (ul < N) begin
          c          = out_data;
          got_re[ul] = int'(c.re);
          got_im[ul] = int'(c.im);
        end
        ul++;
      end
      stalled   = out_valid && !out_ready;
      prev_data = out_data;
      prev_idx  = out_index;
      @(posedge clk);
      #1;
      cyc++;
      if (take_in) ld++;
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("frame_done_seen", (done_cyc > 0), 1'b1);
    chk("bins_transferred", ul, N);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    int dc;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    start       = 1'b0;
    inverse     = 1'b0;
    scale_en    = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Impulse, unscaled, with latency check.
    for (int n = 0; n < N; n++) begin
      x_re[n] = 0;
      x_im[n] = 0;
    end
    x_re[0] = 1000;
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, -1, dc);
    chk("impulse_latency", dc, 1 + N + 4 * N / 2 + N);
    ref_model(1'b0, 1'b0);
    cmp_all("impulse", 0.01);

    // DC, scaled and unscaled.
    for (int n = 0; n < N; n++) x_re[n] = 100;
    run_frame(1'b0, 1'b1, 1'b0, 1'b0, -1, dc);
    ref_model(1'b0, 1'b1);
    cmp_all("dc_scaled", 0.01);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, -1, dc);
    ref_model(1'b0, 1'b0);
    cmp_all("dc_unscaled", 0.01);

    // Tone forward, then inverse of its rounded spectrum with scaling.
    for (int n = 0; n < N; n++) begin
      x_re[n] = int'(1000.0 * $cos(2.0 * 3.14159265358979323846 * real'(n) / real'(N)));
      x_im[n] = 0;
    end
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, -1, dc);
    ref_model(1'b0, 1'b0);
    cmp_all("tone_fwd", 2.0);
    for (int k = 0; k < N; k++) begin
      x_re[k] = int'(exp_re[k]);
      x_im[k] = int'(exp_im[k]);
    end
    run_frame(1'b1, 1'b1, 1'b0, 1'b0, -1, dc);
    ref_model(1'b1, 1'b1);
    cmp_all("tone_inv", 2.0);

    // Saturation on the first stage.
    for (int n = 0; n < N; n++) begin
      x_re[n] = 32767;
      x_im[n] = 0;
    end
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, -1, dc);
    for (int k = 0; k < N; k++) begin
      chk("sat_re", got_re[k], (k == 0) ? 32767 : 0);
      chk("sat_im", got_im[k], 0);
    end

    // Backpressure plus a stray start mid-COMPUTE.
    fill_random(12000);
    run_frame(1'b0, 1'b1, 1'b1, 1'b1, -1, dc);
    ref_model(1'b0, 1'b1);
    cmp_all("backpressure", 3.5);

    // Abort mid-COMPUTE, then a clean frame.
    fill_random(1000);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 30, dc);
    fill_random(1000);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, -1, dc);
    chk("post_abort_latency", dc, 1 + N + 4 * N / 2 + N);
    ref_model(1'b0, 1'b0);
    cmp_all("post_abort", 4.0);

    // Random frames over both directions and scaling modes.
    for (int f = 0; f < 4; f++) begin
      bit inv_f, scl_f;
      inv_f = f[0];
      scl_f = f[1];
      fill_random(scl_f ? 12000 : 1000);
      run_frame(inv_f, scl_f, f[0], 1'b0, -1, dc);
      ref_model(inv_f, scl_f);
      cmp_all("random", scl_f ? 3.5 : 4.0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
